axi_lite_regfile_endpoint: RTL and testbench

AXI-Lite responder that terminates one endpoint port of the AXI crossbar and exposes a bank of word-wide read/write registers to fabric logic. It accepts reads and writes on base-subtracted offset addresses, applies byte strobes, returns read data and write responses with full valid/ready handshakes, and pulses a per-register strobe on every committed write.

---
 rtl/axi_lite_regfile_endpoint.sv | 188 ++++++++++++++++++
 tb/tb_axi_lite_regfile_endpoint.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile_endpoint.sv
// AXI-Lite register-file endpoint: NUM_REGS word registers with byte strobes, read/write FSMs and per-register write pulses.
// Optional build macro AXI_REGFILE_SLVERR_EN: out-of-range writes answer SLVERR on b_response instead of OKAY.
module axi_lite_regfile_endpoint #(
    parameter int NUM_REGS = 16,
    parameter int BUSWIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  axi_araddr,
    input  logic                         axi_arvalid,
    output logic                         axi_arready,
    output logic [BUSWIDTH-1:0]          axi_rdata,
    output logic                         axi_rvalid,
    input  logic                         axi_rready,
    input  logic [31:0]                  axi_awaddr,
    input  logic                         axi_awvalid,
    output logic                         axi_awready,
    input  logic [BUSWIDTH-1:0]          axi_wdata,
    input  logic [3:0]                   axi_wstrb,
    input  logic                         axi_wvalid,
    output logic                         axi_wready,
    input  logic                         b_ready,
    output logic                         b_valid,
    output logic [1:0]                   b_response,
    output logic [BUSWIDTH*NUM_REGS-1:0] regs_out,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [1:0]                   rd_state_dbg,
    output logic [1:0]                   wr_state_dbg
);

    localparam int IDXW   = $clog2(NUM_REGS);
    localparam int NBYTES = BUSWIDTH / 8;

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid keeps its payload until then.
    // Readies and valids are pure decodes of registered state.

    typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_RST, W_IDLE, W_HALF, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [BUSWIDTH-1:0] regs [NUM_REGS];

    logic        aw_cap, w_cap;
    logic [29:0] aw_word_q;
    logic [BUSWIDTH-1:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic ar_hs, aw_hs, w_hs, commit;
    logic [IDXW-1:0] rd_idx, wr_idx;
    logic rd_in_range, wr_in_range;
    logic [29:0] wr_word;
    logic [BUSWIDTH-1:0] wr_data;
    logic [3:0] wr_strb;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_araddr[1:0], axi_awaddr[1:0]};

    assign ar_hs = axi_arvalid & axi_arready;
    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;
    // Commit on the edge where the later of the two halves arrives (or both together).
    assign commit = (aw_hs | aw_cap) & (w_hs | w_cap);

    assign rd_idx      = axi_araddr[2 +: IDXW];
    assign rd_in_range = (axi_araddr[31:2] >> IDXW) == '0;

    assign wr_word     = aw_cap ? aw_word_q : axi_awaddr[31:2];
    assign wr_data     = w_cap ? w_data_q : axi_wdata;
    assign wr_strb     = w_cap ? w_strb_q : axi_wstrb;
    assign wr_idx      = wr_word[IDXW-1:0];
    assign wr_in_range = (wr_word >> IDXW) == '0;

    assign rd_state_dbg = r_state;
    assign wr_state_dbg = w_state;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_RST;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_RST:   r_next = R_IDLE;
            R_IDLE:  if (axi_arvalid) r_next = R_DATA;
            R_DATA:  if (axi_rready) r_next = R_IDLE;
            default: r_next = R_RST;
        endcase
    end

    always_comb begin
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  axi_arready = 1'b1;
            R_DATA:  axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read data is sampled from the pre-edge register values, so a same-edge write is not visible.
    always_ff @(posedge clk) begin
        if (rst)        axi_rdata <= '0;
        else if (ar_hs) axi_rdata <= rd_in_range ? regs[rd_idx] : '0;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_RST;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_RST:   w_next = W_IDLE;
            W_IDLE:  if (commit) w_next = W_RESP;
                     else if (aw_hs || w_hs) w_next = W_HALF;
            W_HALF:  if (commit) w_next = W_RESP;
            W_RESP:  if (b_ready) w_next = W_IDLE;
            default: w_next = W_RST;
        endcase
    end

    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        b_valid     = 1'b0;
        case (w_state)
            W_IDLE, W_HALF: begin
                axi_awready = ~aw_cap;
                axi_wready  = ~w_cap;
            end
            W_RESP:  b_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture flags, register bank, write pulses and response code.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_cap     <= 1'b0;
            w_cap      <= 1'b0;
            aw_word_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_pulse   <= '0;
            b_response <= 2'b00;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                aw_cap <= 1'b0;
                w_cap  <= 1'b0;
                if (wr_in_range) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                    wr_pulse[wr_idx] <= 1'b1;
                end
`ifdef AXI_REGFILE_SLVERR_EN
                b_response <= wr_in_range ? 2'b00 : 2'b10;
`else
                b_response <= 2'b00;
`endif
            end else begin
                if (aw_hs) begin
                    aw_cap    <= 1'b1;
                    aw_word_q <= axi_awaddr[31:2];
                end
                if (w_hs) begin
                    w_cap    <= 1'b1;
                    w_data_q <= axi_wdata;
                    w_strb_q <= axi_wstrb;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[k*BUSWIDTH +: BUSWIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axi_lite_regfile_endpoint.sv
// Directed bench for axi_lite_regfile_endpoint (NUM_REGS=16): reset, strobed writes, split AW/W,
// read backpressure, out-of-range access, read/write collision and mid-transaction reset.
module tb_axi_lite_regfile_endpoint;

    logic         clk;
    logic         rst;
    logic [31:0]  axi_araddr;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [31:0]  axi_rdata;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [31:0]  axi_awaddr;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [31:0]  axi_wdata;
    logic [3:0]   axi_wstrb;
    logic         axi_wvalid;
    logic         axi_wready;
    logic         b_ready;
    logic         b_valid;
    logic [1:0]   b_response;
    logic [511:0] regs_out;
    logic [15:0]  wr_pulse;
    logic [1:0]   rd_state_dbg;
    logic [1:0]   wr_state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_regs [16];
    logic [31:0] exp_q [$];

`ifdef AXI_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    axi_lite_regfile_endpoint #(.NUM_REGS(16), .BUSWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .b_ready(b_ready), .b_valid(b_valid),
        .b_response(b_response), .regs_out(regs_out), .wr_pulse(wr_pulse),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] model_regs();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = exp_regs[k];
        return r;
    endfunction

    task automatic check_readies(input string tag, input logic exp);
        check({tag, "_arready"}, axi_arready, exp);
        check({tag, "_awready"}, axi_awready, exp);
        check({tag, "_wready"},  axi_wready,  exp);
    endtask

    // scoreboard: compare read data against the oldest expected entry
    task automatic check_rdata(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0h expected <empty queue>", tag, axi_rdata);
        end else begin
            e = exp_q.pop_front();
            check(tag, axi_rdata, e);
        end
    endtask

    // driver: AW and W together, then accept the response
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi_awaddr = addr; axi_awvalid = 1'b1;
        axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        check("wr_bvalid", b_valid, 1'b1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; b_ready = 1'b0;
        for (int k = 0; k < 16; k++) exp_regs[k] = '0;
        @(negedge clk);
        tick();

        // reset values
        check_readies("rst", 1'b0);
        check("rst_rvalid", axi_rvalid, 1'b0);
        check("rst_rdata", axi_rdata, 32'h0);
        check("rst_bvalid", b_valid, 1'b0);
        check("rst_bresp", b_response, 2'b00);
        check("rst_regs", regs_out, model_regs());
        check("rst_pulse", wr_pulse, 16'h0);
        rst = 1'b0;
        tick();
        check_readies("post_rst", 1'b1);

        // T1: write 0x8 with AW and W in the same cycle
        axi_awaddr = 32'h8; axi_awvalid = 1'b1;
        axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        exp_regs[2] = 32'hDEADBEEF;
        check("t1_bvalid", b_valid, 1'b1);
        check("t1_bresp", b_response, 2'b00);
        check("t1_regs", regs_out, model_regs());
        check("t1_pulse", wr_pulse, 16'h0004);
        check("t1_awready_resp", axi_awready, 1'b0);
        tick();
        check("t1_pulse_low", wr_pulse, 16'h0);
        check("t1_bvalid_held", b_valid, 1'b1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("t1_bvalid_done", b_valid, 1'b0);
        check("t1_awready_back", axi_awready, 1'b1);

        // T2: W three cycles ahead of AW, partial strobe on reg1
        write_word(32'h4, 32'hFFFFFFFF, 4'hF);
        exp_regs[1] = 32'hFFFFFFFF;
        check("t2_preload", regs_out, model_regs());
        axi_wdata = 32'h1234ABCD; axi_wstrb = 4'b0011; axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        check("t2_wready_low", axi_wready, 1'b0);
        check("t2_awready_high", axi_awready, 1'b1);
        check("t2_no_bvalid", b_valid, 1'b0);
        tick();
        tick();
        check("t2_regs_before_aw", regs_out, model_regs());
        check("t2_wready_still_low", axi_wready, 1'b0);
        axi_awaddr = 32'h4; axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        exp_regs[1] = 32'hFFFFABCD;
        check("t2_regs", regs_out, model_regs());
        check("t2_bvalid", b_valid, 1'b1);
        check("t2_pulse", wr_pulse, 16'h0002);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;

        // T3: read 0x8 with rready held low for 5 cycles
        axi_araddr = 32'h8; axi_arvalid = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_rvalid_held", axi_rvalid, 1'b1);
            check("t3_rdata_stable", axi_rdata, 32'hDEADBEEF);
            check("t3_arready_low", axi_arready, 1'b0);
            tick();
        end
        axi_rready = 1'b1;
        check_rdata("t3_rdata_sb");
        tick();
        axi_rready = 1'b0;
        check("t3_rvalid_done", axi_rvalid, 1'b0);
        check("t3_arready_back", axi_arready, 1'b1);

        // T4: out-of-range write 0x40 and read 0x44
        axi_awaddr = 32'h40; axi_awvalid = 1'b1;
        axi_wdata = 32'hA5A5A5A5; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        check("t4_regs_unchanged", regs_out, model_regs());
        check("t4_no_pulse", wr_pulse, 16'h0);
        check("t4_bvalid", b_valid, 1'b1);
        check("t4_bresp", b_response, OOR_RESP);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        axi_araddr = 32'h44; axi_arvalid = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        axi_arvalid = 1'b0;
        check("t4_rvalid", axi_rvalid, 1'b1);
        axi_rready = 1'b1;
        check_rdata("t4_rdata_oor");
        tick();
        axi_rready = 1'b0;

        // T5: read and write reg3 on the same edge -> read sees old value
        axi_araddr = 32'hC; axi_arvalid = 1'b1;
        axi_awaddr = 32'hC; axi_awvalid = 1'b1;
        axi_wdata = 32'h55; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        exp_regs[3] = 32'h55;
        check_rdata("t5_rdata_old");
        check("t5_regs", regs_out, model_regs());
        check("t5_pulse", wr_pulse, 16'h0008);
        axi_rready = 1'b1; b_ready = 1'b1;
        tick();
        axi_rready = 1'b0; b_ready = 1'b0;
        check("t5_rvalid_done", axi_rvalid, 1'b0);
        check("t5_bvalid_done", b_valid, 1'b0);

        // back-to-back reads with rready high: two-cycle throughput
        axi_rready = 1'b1;
        axi_araddr = 32'hC; axi_arvalid = 1'b1;
        exp_q.push_back(32'h55);
        tick();
        check_rdata("b2b_rdata0");
        check("b2b_arready_n1", axi_arready, 1'b0);
        axi_araddr = 32'h4;
        exp_q.push_back(32'hFFFFABCD);
        tick();
        check("b2b_arready_n2", axi_arready, 1'b1);
        check("b2b_rvalid_n2", axi_rvalid, 1'b0);
        tick();
        axi_arvalid = 1'b0;
        check("b2b_rvalid_n3", axi_rvalid, 1'b1);
        check_rdata("b2b_rdata1");
        tick();
        axi_rready = 1'b0;
        check("b2b_rvalid_done", axi_rvalid, 1'b0);

        // sparse strobe 4'b1001 on reg7
        write_word(32'h1C, 32'h11223344, 4'b1001);
        exp_regs[7] = 32'h11000044;
        check("strb_1001", regs_out, model_regs());

        // T6: reset while b_valid=1 and b_ready=0
        axi_awaddr = 32'h14; axi_awvalid = 1'b1;
        axi_wdata = 32'h77; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        exp_regs[5] = 32'h77;
        check("t6_bvalid_pending", b_valid, 1'b1);
        check("t6_regs_written", regs_out, model_regs());
        rst = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) exp_regs[k] = '0;
        check("t6_bvalid_dropped", b_valid, 1'b0);
        check("t6_regs_cleared", regs_out, model_regs());
        check("t6_rvalid", axi_rvalid, 1'b0);
        check("t6_pulse", wr_pulse, 16'h0);
        check_readies("t6_in_rst", 1'b0);
        rst = 1'b0;
        tick();
        check_readies("t6_post_rst", 1'b1);
        check("t6_bvalid_post", b_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
